sd_sector_read_arbiter: RTL and testbench
=========================================

// Module: sd_sector_read_arbiter
// PURPOSE
//  - Shares one sd_spi_sector_reader between N_REQ requesters (e.g. UART dumper, FAT walker).
//  - Round-robin grant; captures the winner's sector number and drives the reader's start/sector_no.
//  - Routes the reader's byte stream and sector-done back to the current owner only.
// PARAMETERS
//  N_REQ    2  number of requesters, 2..8
//  HOLDOFF  2  cycles rd_start is held low between sectors (>=1)
// PORTS
//  clk             in   1         system clock
//  rst_n           in   1         async active-low reset
//  req             in   N_REQ     per-requester read request, level, held until gnt
//  req_sector      in   32*N_REQ  sector number, slice i = [32*i+31:32*i], valid while req[i]
//  gnt             out  N_REQ     one-hot, 1-cycle pulse: request accepted, sector latched
//  done            out  N_REQ     one-hot, 1-cycle pulse: owner's sector complete
//  rvalid          out  N_REQ     per-requester byte strobe (rd_rvalid gated to owner)
//  rdata           out  8         shared byte bus (= rd_rdata)
//  busy            out  1         a sector read is in flight
//  owner           out  3         index of current/last owner
//  rd_start        out  1         to reader .start, level, held until rd_done
//  rd_sector_no    out  32        to reader .sector_no, stable while rd_start=1
//  rd_done         in   1         from reader .done, 1-cycle pulse
//  rd_rvalid       in   1         from reader .rvalid
//  rd_rdata        in   8         from reader .rdata
// BEHAVIOUR
//  - Reset (async): state=IDLE; gnt, done, busy, rd_start=0; rd_sector_no=0; owner=0; rr_ptr=0.
//  - States: IDLE -> READ -> GAP -> IDLE. All outputs registered except rvalid/rdata.
//  - IDLE: if |req, pick first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//    Next edge: gnt[w]=1 (one cycle), owner=w, rd_sector_no=req_sector[w], rd_start=1,
//    busy=1, state=READ. Grant latency: 1 cycle from req sampled high in IDLE.
//  - READ: rd_start held 1. On rd_done=1: next edge rd_start=0, done[owner]=1 (one cycle),
//    rr_ptr=(owner+1) mod N_REQ, busy=0, state=GAP, gap counter=HOLDOFF-1.
//  - GAP: rd_start=0; count down; at 0 -> IDLE. No grant issued in GAP (reader sees start low
//    for exactly HOLDOFF cycles before the next start).
//  - rvalid[i] = rd_rvalid & (state==READ) & (owner==i); rdata = rd_rdata (combinational).
//    rd_rvalid outside READ is dropped. rd_rvalid and rd_done in the same cycle: byte delivered.
//  - req changes while READ/GAP: ignored until IDLE. req[i] dropped before gnt: not granted.
//  - Requester must deassert req the cycle after gnt unless it wants another sector; a held
//    req is treated as a new request after GAP (back-to-back reads, fair via rr_ptr).
//  - rd_done while not in READ: ignored. Reset mid-READ: rd_start falls immediately, no done.
//  - owner upper bits unused for N_REQ<=4 are 0.
// CONFIGURATION
//  - SD_ARB_BYTECHECK_EN defined: adds output `err  out  N_REQ` (1-cycle pulse, same cycle as
//    done) set when bytes counted on rvalid[owner] during READ != 512. Counter 10 bits, saturates
//    at 1023, cleared on each grant. Reset: err=0.
//  - Not defined: no err port, no counter; behaviour otherwise identical.
// TESTING
//  - N_REQ=2, req=01, sector0=0x5 -> gnt=01 next cycle, rd_sector_no=0x5, rd_start=1; model
//    gives 512 bytes + rd_done -> rvalid[0] 512 pulses, rvalid[1] none, done=01 one cycle.
//  - req=11 held, sectors 0x10/0x20 -> grant order 0,1,0,1; rd_start low exactly HOLDOFF=2
//    cycles between sectors; rd_sector_no alternates 0x10/0x20.
//  - req[1] raised mid-READ of req[0] -> no gnt until GAP ends; then gnt=10 in first IDLE cycle.
//  - rst_n low at byte 100 of a read -> rd_start, busy, gnt, done =0 asynchronously; after
//    release req=10 -> requester 1 granted (rr_ptr=0, req[0] low).
//  - rd_rvalid pulses in IDLE/GAP and stray rd_done in IDLE -> no rvalid/done on any requester.
//  - SD_ARB_BYTECHECK_EN: model sends 511 bytes then rd_done -> err[owner]=1 with done;
//    512 bytes -> err=0.

Source files
------------

// File: rtl/sd_sector_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sd_sector_read_arbiter
// Round-robin sharing of one SD SPI sector reader between N_REQ requesters.
// Optional build macro SD_ARB_BYTECHECK_EN adds a per-sector 512-byte check (err).
// Rev    : 1.0
// ============================================================================
module sd_sector_read_arbiter #(
    parameter int N_REQ   = 2,
    parameter int HOLDOFF = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] req_sector,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [N_REQ-1:0]    rvalid,
    output logic [7:0]          rdata,
    output logic                busy,
    output logic [2:0]          owner,
`ifdef SD_ARB_BYTECHECK_EN
    output logic [N_REQ-1:0]    err,
`endif
    output logic                rd_start,
    output logic [31:0]         rd_sector_no,
    input  logic                rd_done,
    input  logic                rd_rvalid,
    input  logic [7:0]          rd_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // GAP lasts HOLDOFF-1 cycles; the following IDLE cycle supplies the last low cycle.
    localparam int             GW       = (HOLDOFF > 2) ? $clog2(HOLDOFF - 1) : 1;
    localparam logic [GW-1:0]  GAP_LOAD = GW'((HOLDOFF > 1) ? HOLDOFF - 2 : 0);

    state_t            r_state, w_state_nx;
    logic [2:0]        r_rr_ptr, w_rr_nx;
    logic [GW-1:0]     r_gap_cnt, w_gap_nx;
    logic [N_REQ-1:0]  w_gnt_nx, w_done_nx;
    logic              w_busy_nx, w_start_nx;
    logic [31:0]       w_sector_nx;
    logic [2:0]        w_owner_nx;

    logic [N_REQ-1:0]  w_req_rot;
    logic              w_found;
    logic [2:0]        w_off;
    logic [3:0]        w_sum;
    logic [2:0]        w_win;
    logic [31:0]       w_win_sector;
    logic [2:0]        w_owner_inc;

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    always_comb begin
        w_req_rot = N_REQ'({req, req} >> r_rr_ptr);
        w_found   = 1'b0;
        w_off     = 3'd0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_found && w_req_rot[j]) begin
                w_found = 1'b1;
                w_off   = 3'(j);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= 4'(N_REQ)) begin
            w_sum = w_sum - 4'(N_REQ);
        end
        w_win        = w_sum[2:0];
        w_win_sector = 32'd0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == 3'(i)) begin
                w_win_sector = req_sector[32*i +: 32];
            end
        end
        w_owner_inc = (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_gnt_nx    = '0;
        w_done_nx   = '0;
        w_busy_nx   = busy;
        w_start_nx  = rd_start;
        w_sector_nx = rd_sector_no;
        w_owner_nx  = owner;
        w_rr_nx     = r_rr_ptr;
        w_gap_nx    = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        w_gnt_nx[i] = (w_win == 3'(i));
                    end
                    w_owner_nx  = w_win;
                    w_sector_nx = w_win_sector;
                    w_start_nx  = 1'b1;
                    w_busy_nx   = 1'b1;
                    w_state_nx  = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_done) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        w_done_nx[i] = (owner == 3'(i));
                    end
                    w_start_nx = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_rr_nx    = w_owner_inc;
                    w_gap_nx   = GAP_LOAD;
                    w_state_nx = (HOLDOFF > 1) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_gap_nx = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_start_nx = 1'b0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= 3'd0;
            r_gap_cnt    <= '0;
            gnt          <= '0;
            done         <= '0;
            busy         <= 1'b0;
            rd_start     <= 1'b0;
            rd_sector_no <= 32'd0;
            owner        <= 3'd0;
        end else begin
            r_state      <= w_state_nx;
            r_rr_ptr     <= w_rr_nx;
            r_gap_cnt    <= w_gap_nx;
            gnt          <= w_gnt_nx;
            done         <= w_done_nx;
            busy         <= w_busy_nx;
            rd_start     <= w_start_nx;
            rd_sector_no <= w_sector_nx;
            owner        <= w_owner_nx;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rvalid[i] = rd_rvalid && (r_state == ST_READ) && (owner == 3'(i));
        end
    end

    assign rdata = rd_rdata;

`ifdef SD_ARB_BYTECHECK_EN
    logic [9:0]       r_byte_cnt, w_byte_inc;
    logic [N_REQ-1:0] w_err_nx;

    // The byte arriving together with rd_done still counts toward the sector total.
    always_comb begin
        w_byte_inc = (rd_rvalid && (r_byte_cnt != 10'h3FF)) ? r_byte_cnt + 10'd1 : r_byte_cnt;
        w_err_nx   = '0;
        if ((r_state == ST_READ) && rd_done && (w_byte_inc != 10'd512)) begin
            for (int i = 0; i < N_REQ; i++) begin
                w_err_nx[i] = (owner == 3'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= 10'd0;
            err        <= '0;
        end else begin
            err <= w_err_nx;
            if ((r_state == ST_IDLE) && w_found) begin
                r_byte_cnt <= 10'd0;
            end else if (r_state == ST_READ) begin
                r_byte_cnt <= w_byte_inc;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_read_arbiter.sv
`default_nettype none
// Directed bench for sd_sector_read_arbiter (N_REQ=2, HOLDOFF=2) driving a simple reader model.
module tb_sd_sector_read_arbiter;

    localparam int N_REQ   = 2;
    localparam int HOLDOFF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [63:0] req_sector = 64'd0;
    logic [1:0]  gnt, done, rvalid;
    logic [7:0]  rdata;
    logic        busy;
    logic [2:0]  owner;
    logic        rd_start;
    logic [31:0] rd_sector_no;
    logic        rd_done = 1'b0;
    logic        rd_rvalid = 1'b0;
    logic [7:0]  rd_rdata = 8'd0;
`ifdef SD_ARB_BYTECHECK_EN
    logic [1:0]  err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int rv0_cnt     = 0;
    int rv1_cnt     = 0;
    int done_cnt    = 0;

    sd_sector_read_arbiter #(.N_REQ(N_REQ), .HOLDOFF(HOLDOFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_sector   (req_sector),
        .gnt          (gnt),
        .done         (done),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .busy         (busy),
        .owner        (owner),
`ifdef SD_ARB_BYTECHECK_EN
        .err          (err),
`endif
        .rd_start     (rd_start),
        .rd_sector_no (rd_sector_no),
        .rd_done      (rd_done),
        .rd_rvalid    (rd_rvalid),
        .rd_rdata     (rd_rdata)
    );

    always #5 clk = ~clk;

    // Inputs move just after posedge, so the negedge sees every pulse exactly once.
    always @(negedge clk) begin
        if (rvalid[0]) rv0_cnt = rv0_cnt + 1;
        if (rvalid[1]) rv1_cnt = rv1_cnt + 1;
        if (done != 2'b00) done_cnt = done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = 2'b00; rd_done = 1'b0; rd_rvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (gnt == 2'b00 && cycles < 40);
    endtask

    task automatic serve(input int n, input bit together);
        for (int b = 0; b < n; b++) begin
            rd_rvalid = 1'b1;
            rd_rdata  = 8'(b);
            if (together && b == n - 1) rd_done = 1'b1;
            tick();
        end
        rd_rvalid = 1'b0;
        if (!together) begin
            rd_done = 1'b1;
            tick();
        end
        rd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b11; req_sector = {32'h22, 32'h11};
        rd_done = 1'b1; rd_rvalid = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({gnt, done, busy, rd_start, owner} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, want 0", {gnt, done, busy, rd_start, owner});
        end
        vectors++;
        if (rd_sector_no !== 32'd0 || rvalid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_sector: got %h/%b, want 0/00", rd_sector_no, rvalid);
        end
        rd_done = 1'b0; rd_rvalid = 1'b0; req = 2'b00;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (gnt !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got gnt=%b busy=%b, want 00/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        int c, r0, r1;
        apply_reset();
        req_sector[31:0] = 32'h5; req = 2'b01;
        r0 = rv0_cnt; r1 = rv1_cnt;
        wait_gnt(c);
        vectors++;
        if (c !== 1 || gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL single_gnt: got c=%0d gnt=%b, want 1/01", c, gnt);
        end
        vectors++;
        if (rd_sector_no !== 32'h5 || rd_start !== 1'b1 || busy !== 1'b1 || owner !== 3'd0) begin
            miscompares++;
            $display("FAIL single_start: got sec=%h st=%b busy=%b own=%0d, want 5/1/1/0",
                     rd_sector_no, rd_start, busy, owner);
        end
        req = 2'b00;
        serve(512, 1'b0);
        vectors++;
        if (done !== 2'b01 || rd_start !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got done=%b st=%b busy=%b, want 01/0/0", done, rd_start, busy);
        end
        tick();
        vectors++;
        if (done !== 2'b00) begin
            miscompares++;
            $display("FAIL single_done_pulse: got %b, want 00", done);
        end
        vectors++;
        if (rv0_cnt - r0 !== 512 || rv1_cnt - r1 !== 0) begin
            miscompares++;
            $display("FAIL single_bytes: got %0d/%0d, want 512/0", rv0_cnt - r0, rv1_cnt - r1);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [1:0]  exp_g;
        logic [31:0] exp_s;
        apply_reset();
        req_sector = {32'h20, 32'h10}; req = 2'b11;
        for (int s = 0; s < 4; s++) begin
            wait_gnt(c);
            exp_g = (s % 2 == 0) ? 2'b01 : 2'b10;
            exp_s = (s % 2 == 0) ? 32'h10 : 32'h20;
            vectors++;
            if (gnt !== exp_g || rd_sector_no !== exp_s || rd_start !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_grant%0d: got gnt=%b sec=%h st=%b, want %b/%h/1",
                         s, gnt, rd_sector_no, rd_start, exp_g, exp_s);
            end
            vectors++;
            if (c !== ((s == 0) ? 1 : HOLDOFF)) begin
                miscompares++;
                $display("FAIL b2b_low_cycles%0d: got %0d, want %0d", s, c, (s == 0) ? 1 : HOLDOFF);
            end
            if (s == 3) req = 2'b00;
            serve(8, 1'b0);
        end
        repeat (3) tick();
        vectors++;
        if (rd_start !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got st=%b busy=%b, want 0/0", rd_start, busy);
        end
    endtask

    task automatic test_mid_read();
        int c;
        bit stray;
        apply_reset();
        req_sector = {32'h33, 32'h7}; req = 2'b01;
        wait_gnt(c);
        req = 2'b00;
        stray = 1'b0;
        for (int b = 0; b < 8; b++) begin
            rd_rvalid = 1'b1;
            if (b == 3) req = 2'b10;
            tick();
            if (gnt !== 2'b00) stray = 1'b1;
        end
        rd_rvalid = 1'b0; rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        if (gnt !== 2'b00) stray = 1'b1;
        vectors++;
        if (stray || done !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_no_gnt: got stray=%0d done=%b, want 0/01", stray, done);
        end
        wait_gnt(c);
        vectors++;
        if (c !== HOLDOFF || gnt !== 2'b10 || rd_sector_no !== 32'h33 || owner !== 3'd1) begin
            miscompares++;
            $display("FAIL mid_gnt1: got c=%0d gnt=%b sec=%h own=%0d, want %0d/10/33/1",
                     c, gnt, rd_sector_no, owner, HOLDOFF);
        end
        req = 2'b00;
        serve(4, 1'b0);
        vectors++;
        if (done !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_done1: got %b, want 10", done);
        end
    endtask

    task automatic test_reset_mid_read();
        int c, d0;
        apply_reset();
        req_sector = {32'h44, 32'h9}; req = 2'b01;
        wait_gnt(c);
        req = 2'b00;
        for (int b = 0; b < 100; b++) begin
            rd_rvalid = 1'b1;
            tick();
        end
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rd_start !== 1'b0 || busy !== 1'b0 || gnt !== 2'b00 || done !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_async: got st=%b busy=%b gnt=%b done=%b, want 0/0/00/00",
                     rd_start, busy, gnt, done);
        end
        rd_rvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        req = 2'b10;
        wait_gnt(c);
        vectors++;
        if (gnt !== 2'b10 || owner !== 3'd1 || c !== 1 || rd_sector_no !== 32'h44) begin
            miscompares++;
            $display("FAIL rst_regrant: got gnt=%b own=%0d c=%0d sec=%h, want 10/1/1/44",
                     gnt, owner, c, rd_sector_no);
        end
        req = 2'b00;
        serve(2, 1'b0);
        vectors++;
        if (done !== 2'b10 || done_cnt !== d0) begin
            miscompares++;
            $display("FAIL rst_done: got done=%b extra=%0d, want 10/0", done, done_cnt - d0);
        end
    endtask

    task automatic test_stray();
        int c, d0, r0, r1;
        apply_reset();
        d0 = done_cnt; r0 = rv0_cnt; r1 = rv1_cnt;
        rd_rvalid = 1'b1; rd_rdata = 8'h3C;
        #1;
        vectors++;
        if (rvalid !== 2'b00 || rdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL stray_idle_rv: got rv=%b rdata=%h, want 00/3c", rvalid, rdata);
        end
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        rd_rvalid = 1'b0;
        tick();
        vectors++;
        if (done_cnt !== d0 || rv0_cnt !== r0 || rv1_cnt !== r1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_idle: got done+%0d rv+%0d/%0d busy=%b, want 0/0/0/0",
                     done_cnt - d0, rv0_cnt - r0, rv1_cnt - r1, busy);
        end
        req_sector[31:0] = 32'h77; req = 2'b01;
        wait_gnt(c);
        req = 2'b00;
        serve(6, 1'b1);
        vectors++;
        if (done !== 2'b01 || rv0_cnt - r0 !== 6) begin
            miscompares++;
            $display("FAIL stray_same_cycle: got done=%b bytes=%0d, want 01/6", done, rv0_cnt - r0);
        end
        rd_rvalid = 1'b1; rd_done = 1'b1;
        #1;
        vectors++;
        if (rvalid !== 2'b00) begin
            miscompares++;
            $display("FAIL stray_gap_rv: got %b, want 00", rvalid);
        end
        repeat (2) tick();
        rd_rvalid = 1'b0; rd_done = 1'b0;
        tick();
        vectors++;
        if (done_cnt - d0 !== 1 || rv0_cnt - r0 !== 6 || rv1_cnt !== r1 || rd_start !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_gap: got done+%0d rv0+%0d rv1+%0d st=%b, want 1/6/0/0",
                     done_cnt - d0, rv0_cnt - r0, rv1_cnt - r1, rd_start);
        end
    endtask

`ifdef SD_ARB_BYTECHECK_EN
    task automatic test_bytecheck();
        int c;
        apply_reset();
        req_sector[31:0] = 32'h1; req = 2'b01;
        wait_gnt(c);
        req = 2'b00;
        serve(511, 1'b0);
        vectors++;
        if (err !== 2'b01 || done !== 2'b01) begin
            miscompares++;
            $display("FAIL bc_short: got err=%b done=%b, want 01/01", err, done);
        end
        tick();
        vectors++;
        if (err !== 2'b00) begin
            miscompares++;
            $display("FAIL bc_pulse: got %b, want 00", err);
        end
        req = 2'b01;
        wait_gnt(c);
        req = 2'b00;
        serve(512, 1'b1);
        vectors++;
        if (err !== 2'b00 || done !== 2'b01) begin
            miscompares++;
            $display("FAIL bc_full: got err=%b done=%b, want 00/01", err, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mid_read();
        test_reset_mid_read();
        test_stray();
`ifdef SD_ARB_BYTECHECK_EN
        test_bytecheck();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
